// File: rtl/mem_arbiter.sv
// Round-robin arbiter and fixed-latency sequencer sharing one memory port
// between the CPU memory interface and the debug/loader port.
//
// state | meaning
// IDLE  | no access in progress, requests sampled
// ISSUE | mem_en driven for one cycle
// WAIT  | LAT cycles while memory produces read data
// ACK   | one-cycle ack to the owner, requests ignored
module mem_arbiter #(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    input  logic          dbg_halt,
    output logic          halted,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          owner_cpu;
    logic          last_dbg;
    logic          cmd_we;

    logic cpu_elig;
    logic grant;
    logic grant_cpu;

    assign cpu_elig  = cpu_req & ~dbg_halt;
    assign grant     = cpu_elig | dbg_req;
    // On a tie the side not granted last wins; last_dbg resets high so the CPU wins first.
    assign grant_cpu = cpu_elig & (~dbg_req | last_dbg);

    // busy mirrors state != IDLE, so halted only drops while the CPU owns an access.
    assign halted = dbg_halt & ~(busy & owner_cpu);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner_cpu <= 1'b0;
            last_dbg  <= 1'b1;
            cmd_we    <= 1'b0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        owner_cpu <= grant_cpu;
                        last_dbg  <= ~grant_cpu;
                        cmd_we    <= grant_cpu ? cpu_we : dbg_we;
                        mem_addr  <= grant_cpu ? cpu_addr : dbg_addr;
                        mem_wdata <= grant_cpu ? cpu_wdata : dbg_wdata;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_cpu ? cpu_we : dbg_we;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= CW'(LAT);
                end
                WAIT: begin
                    if (cnt == CW'(1)) begin
                        state   <= ACK;
                        cpu_ack <= owner_cpu;
                        dbg_ack <= ~owner_cpu;
                        if (!cmd_we) begin
                            if (owner_cpu) cpu_rdata <= mem_rdata;
                            else           dbg_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters push expected transactions,
// a negedge monitor models arbitration, timing and memory contents.
module tb_mem_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_halt = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          cpu_ack, dbg_ack, halted, busy, mem_en, mem_we;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .dbg_halt(dbg_halt), .halted(halted), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t          cpu_q[$];
    txn_t          dbg_q[$];
    logic [DW-1:0] ref_mem[logic [AW-1:0]];
    logic [DW-1:0] mem_arr[logic [AW-1:0]];
    int            total = 0;
    int            bad = 0;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / reference model, sampled mid-cycle.
    int            cyc = 0;
    int            en_cyc = -1000;
    bit            own_cpu = 1'b0, last_dbg = 1'b1, prev_cpu = 1'b0, prev_dbg = 1'b0, have_cmd = 1'b0;
    txn_t          cur = '0;
    logic [DW-1:0] rd_val = '0, m_cpu_rdata = '0, m_dbg_rdata = '0;

    always @(negedge clk) begin
        int d;
        bit exp_en;
        cyc++;
        if (!rst) begin
            en_cyc = -1000; last_dbg = 1'b1; prev_cpu = 1'b0; prev_dbg = 1'b0; have_cmd = 1'b0;
            m_cpu_rdata = '0; m_dbg_rdata = '0;
            cpu_q.delete(); dbg_q.delete();
            mem_rdata = DW'($urandom);
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_mem_en", 32'(mem_en), 32'(0));
            chk("rst_cpu_ack", 32'(cpu_ack), 32'(0));
            chk("rst_dbg_ack", 32'(dbg_ack), 32'(0));
            chk("rst_mem_addr", 32'(mem_addr), 32'(0));
            chk("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
        end else begin
            exp_en = (cyc - en_cyc >= LAT + 3) && (prev_cpu || prev_dbg);
            chk("mem_en", 32'(mem_en), 32'(exp_en));
            if (exp_en) begin
                own_cpu  = prev_cpu && (!prev_dbg || last_dbg);
                last_dbg = !own_cpu;
                en_cyc   = cyc;
                have_cmd = 1'b1;
                if ((own_cpu && cpu_q.size() == 0) || (!own_cpu && dbg_q.size() == 0)) begin
                    total++; bad++;
                    $display("FAIL grant_owner: got grant for cpu=%0d want a queued request", own_cpu);
                    cur = '0;
                end else if (own_cpu) begin
                    cur = cpu_q.pop_front();
                end else begin
                    cur = dbg_q.pop_front();
                end
                chk("mem_we", 32'(mem_we), 32'(cur.we));
                if (cur.we) begin
                    chk("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
                    mem_arr[cur.addr] = cur.wdata;
                end else begin
                    rd_val = mem_arr.exists(cur.addr) ? mem_arr[cur.addr] : init_val(cur.addr);
                end
            end else begin
                chk("mem_we_idle", 32'(mem_we), 32'(0));
            end
            d = cyc - en_cyc;
            if (have_cmd) chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
            if (d == LAT + 1 && !cur.we) begin
                if (own_cpu) m_cpu_rdata = cur.rdata;
                else         m_dbg_rdata = cur.rdata;
            end
            chk("busy", 32'(busy), 32'(d <= LAT + 1));
            chk("cpu_ack", 32'(cpu_ack), 32'(d == LAT + 1 && own_cpu));
            chk("dbg_ack", 32'(dbg_ack), 32'(d == LAT + 1 && !own_cpu));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rdata));
            chk("dbg_rdata", 32'(dbg_rdata), 32'(m_dbg_rdata));
            chk("halted", 32'(halted), 32'(dbg_halt && !(own_cpu && d <= LAT + 1)));
            // Memory drives valid data only in cycle LAT of a read; junk otherwise.
            mem_rdata = (d == LAT && !cur.we) ? rd_val : DW'($urandom);
            prev_cpu = cpu_req && !dbg_halt;
            prev_dbg = dbg_req;
        end
    end

    task automatic access(input bit is_dbg, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
        txn_t t;
        int   n;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        t.rdata = ref_mem.exists(addr) ? ref_mem[addr] : init_val(addr);
        if (we) ref_mem[addr] = wdata;
        if (is_dbg) begin
            dbg_q.push_back(t);
            dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
        end else begin
            cpu_q.push_back(t);
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_dbg ? dbg_ack : cpu_ack) && n < 400);
        if (!(is_dbg ? dbg_ack : cpu_ack)) begin
            total++; bad++;
            $display("FAIL ack_timeout: dbg=%0d addr=%h got no ack want ack", is_dbg, addr);
        end
        @(posedge clk);
        #1;
        if (is_dbg) dbg_req = 1'b0;
        else        cpu_req = 1'b0;
    endtask

    task automatic wait_mem_en();
        int n;
        n = 0;
        while (!mem_en && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        txn_t t;
        ref_mem[16'h0010] = 16'hBEEF;
        mem_arr[16'h0010] = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Tie right after reset: CPU, DBG, CPU, DBG.
        fork
            repeat (2) access(1'b0, 1'b0, 16'h0001, '0);
            repeat (2) access(1'b1, 1'b0, 16'h0002, '0);
        join

        access(1'b0, 1'b0, 16'h0010, '0);
        access(1'b1, 1'b1, 16'h0002, 16'h1234);

        // Halt raised during a CPU read's WAIT.
        fork
            access(1'b0, 1'b0, 16'h0020, '0);
            begin
                wait_mem_en();
                @(posedge clk);
                #1 dbg_halt = 1'b1;
            end
        join
        fork
            access(1'b0, 1'b0, 16'h0021, '0);
            begin
                access(1'b1, 1'b1, 16'h8002, 16'h5555);
                repeat (2) @(posedge clk);
                #1 dbg_halt = 1'b0;
            end
        join

        // Reset pulsed during WAIT abandons the access.
        t.we = 1'b0; t.addr = 16'h0030; t.wdata = '0; t.rdata = init_val(16'h0030);
        cpu_q.push_back(t);
        cpu_we = 1'b0; cpu_addr = 16'h0030; cpu_req = 1'b1;
        wait_mem_en();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_now_mem_en", 32'(mem_en), 32'(0));
        chk("rst_now_busy", 32'(busy), 32'(0));
        chk("rst_now_halted", 32'(halted), 32'(0));
        chk("rst_now_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_now_mem_wdata", 32'(mem_wdata), 32'(0));
        chk("rst_now_dbg_rdata", 32'(dbg_rdata), 32'(0));
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        access(1'b0, 1'b0, 16'h0030, '0);

        // Randomised traffic with disjoint address regions and halt toggling.
        fork
            for (int i = 0; i < 25; i++) begin
                access(1'b0, 1'($urandom_range(0, 1)), {12'h000, 4'($urandom)}, DW'($urandom));
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            for (int j = 0; j < 25; j++) begin
                access(1'b1, 1'($urandom_range(0, 1)), {12'h800, 4'($urandom)}, DW'($urandom));
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            begin
                for (int k = 0; k < 20; k++) begin
                    repeat ($urandom_range(1, 12)) @(posedge clk);
                    #1 dbg_halt = 1'($urandom_range(0, 1));
                end
                dbg_halt = 1'b0;
            end
        join

        repeat (10) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish by 500000");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single-ported instruction/data memory of the CPU. It shares the memory between the CPU memory interface (instruction fetch, LD, ST) and the debug/loader port, which downloads programs and inspects memory. Each access runs through a fixed-latency sequence. Grants alternate round-robin, and the debug side can hold the CPU off the memory entirely.

## Interface
- AW, 16, address width
- DW, 16, data width
- LAT, 1, memory read latency in cycles, ≥1: read data is valid LAT cycles after the mem_en cycle

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  CPU write (1) / read (0), stable while cpu_req
- cpu_addr  in  AW  CPU address, stable while cpu_req
- cpu_wdata  in  DW  CPU write data, stable while cpu_req
- cpu_rdata  out  DW  registered CPU read data
- cpu_ack  out  1  one-cycle completion pulse for the CPU access
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/DW  debug request, same rules as the CPU request
- dbg_rdata  out  DW  registered debug read data
- dbg_ack  out  1  one-cycle completion pulse for the debug access
- dbg_halt  in  1  block new CPU grants while high
- halted  out  1  dbg_halt is high and no CPU access is in flight
- busy  out  1  an access is in progress (ISSUE, WAIT or ACK)
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_we  out  1  memory write enable, high only together with mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data

## Operation
- States:
  - IDLE: no access in progress.
  - ISSUE: mem_en is driven for one cycle.
  - WAIT: lasts LAT cycles, counted by a down-counter of width $clog2(LAT+1).
  - ACK: one cycle, ack pulse to the owner.
- IDLE → ISSUE when there is an eligible request:
  - dbg_req is always eligible.
  - cpu_req is eligible only when dbg_halt=0.
  - On the grant edge the arbiter latches owner, we, addr and wdata.
- Arbitration when both requests are eligible:
  - The winner is the requester not granted last.
  - The last-grant register resets to DBG, so the CPU wins the first tie.
  - A single eligible request always wins.
- ISSUE → WAIT. WAIT → ACK when the counter expires. ACK → IDLE unconditionally.
- Requests are not sampled in ACK. This prevents a still-high req from being re-granted.
- Read completion: on the ACK entry edge, mem_rdata is captured into the owner's rdata register. The other requester's rdata holds its value.
- Write completion: both rdata registers hold.
- mem_addr and mem_wdata hold the latched command from ISSUE until the next grant. mem_we = ISSUE & latched we.
- halted = dbg_halt & !(state≠IDLE & owner=CPU). It is combinational from registered state.
- dbg_halt rising during a CPU access does not abort that access. It only blocks the next CPU grant.
- Reset value of all outputs is 0: rdata registers, acks, mem_*, busy, halted. State resets to IDLE.
- Reset mid-access abandons the access. No ack is issued, and the next access after reset proceeds normally.

## Timing
- Edge 0 is the grant edge. Requests are sampled at edge 0 while in IDLE.
- mem_en=1 in cycle 0, the cycle after edge 0.
- Memory drives mem_rdata in cycle LAT. It is captured at edge LAT+1.
- ack=1 and rdata are valid in cycle LAT+1.
- The requester sees ack at edge LAT+2 and must drop req, or change its command, in cycle LAT+2.
- The arbiter is in IDLE in cycle LAT+2. The earliest next grant is edge LAT+3, giving one access per LAT+3 cycles minimum.
- Write latency equals read latency, with ack in cycle LAT+1.
- busy is high in cycles 0 through LAT+1.

## Test plan
- Reset: assert rst low mid-cycle → all outputs 0 immediately; after release with no requests, busy stays 0 and mem_en stays 0.
- CPU read, LAT=1: cpu_addr=0x0010, memory returns 0xBEEF in cycle 1 → mem_en high exactly in cycle 0 with mem_addr=0x0010, cpu_ack high in cycle 2 only, cpu_rdata=0xBEEF, dbg_rdata unchanged.
- Tie after reset: both request reads at 0x0001 and 0x0002 and re-request after each ack → order CPU, DBG, CPU, DBG; each grant at least 4 cycles apart.
- Debug write: dbg_we=1, addr 0x0002, data 0x1234 → mem_we=1 only in the mem_en cycle, mem_wdata=0x1234, dbg_ack in cycle 2, both rdata registers unchanged.
- Halt: dbg_halt rises during a CPU read's WAIT → the read completes with cpu_ack. halted rises in the cycle after ACK. A pending cpu_req is not granted while a debug write completes. After dbg_halt falls, the CPU is granted at the next IDLE sample.
- LAT=3 plus mid-access reset: ack appears in cycle 4. A reset pulsed in WAIT yields no ack, and a following CPU read completes normally.
